pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 169 ++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Single/double-entry pipeline stage carrying a (pc, data) pair with a
// valid/ready handshake on both sides. With SKID=1 the upstream ready is a
// flop, which breaks the combinational out_ready -> in_ready path at the cost
// of a second (skid) entry. With SKID=0 the stage holds one entry and ready
// passes through combinationally. A flush kills every held entry and keeps a
// saturating tally of how many valid entries were thrown away.
module pipe_skid_stage #(
  parameter int              DATA_W   = 64,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hbfc00000,
  parameter int              SKID     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [7:0]        kill_count
);

  // Encoding doubles as the entry count so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_p0;
  state_t            state_nxt;

  logic [PC_W-1:0]   head_pc_p0;
  logic [DATA_W-1:0] head_data_p0;
  logic [PC_W-1:0]   skid_pc_p1;
  logic [DATA_W-1:0] skid_data_p1;

  logic [7:0]        kill_count_q;

  logic              accept;
  logic              pop;
  logic              load_head_in;
  logic              load_head_skid;
  logic              load_skid;
  logic [1:0]        discard;

  // Saturating add for the kill counter: sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, b};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

  assign out_valid = (state_p0 != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = state_p0;
  assign kill_count = kill_count_q;

  // An empty stage presents a fixed, known pair rather than stale contents.
  assign out_pc   = out_valid ? head_pc_p0   : RESET_PC;
  assign out_data = out_valid ? head_data_p0 : '0;

  // Entries lost on a flush: everything held, minus a head that leaves this
  // cycle anyway, plus anything accepted this cycle. A pop implies at least
  // one held entry and TWO never accepts, so this cannot leave 0..2.
  assign discard = occupancy - {1'b0, pop} + {1'b0, accept};

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      // Upstream ready is registered: it looks one step ahead at state_nxt so
      // it is already correct in the cycle the stage becomes full or frees up.
      always_ff @(posedge clk) begin
        if (reset) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_nxt != ST_TWO);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      // Single entry: room exists when empty or when the head leaves now.
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and data-steering decisions; flush overrides accept/pop moves.
  always_comb begin
    state_nxt      = state_p0;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          if (accept) begin
            load_head_in = 1'b1;
            state_nxt    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (accept && !pop && (SKID != 0)) begin
            load_skid = 1'b1;
            state_nxt = ST_TWO;
          end else if (!accept && pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            load_head_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Control state: reset first, then the next-state decision above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ST_EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Kill tally counts only flush discards; a reset clears it without counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      kill_count_q <= 8'd0;
    end else if (flush) begin
      kill_count_q <= sat_add8(kill_count_q, discard);
    end
  end

  // ---- stage p0: head entry (the one presented downstream) ----
  always_ff @(posedge clk) begin
    if (load_head_in) begin
      head_pc_p0   <= in_pc;
      head_data_p0 <= in_data;
    end else if (load_head_skid) begin
      head_pc_p0   <= skid_pc_p1;
      head_data_p0 <= skid_data_p1;
    end
  end

  // ---- stage p1: skid entry, parked while the head is stalled ----
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_pc_p1   <= in_pc;
      skid_data_p1 <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: drives a SKID=1 and a SKID=0 instance with the
// same inputs and compares both against queue-based reference models.
module tb_pipe_skid_stage;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc;
  logic [63:0] a_out_data;
  logic [1:0]  a_occ;
  logic [7:0]  a_kill;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_pc;
  logic [63:0] b_out_data;
  logic [1:0]  b_occ;
  logic [7:0]  b_kill;

  int total = 0;
  int bad   = 0;

  // Reference state: each queue entry is {pc, data}, head at index 0.
  logic [95:0] qa[$];
  logic [95:0] qb[$];
  int          ka = 0;
  int          kb = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(64), .PC_W(32), .RESET_PC(32'hbfc00000), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_data(a_out_data),
    .occupancy(a_occ), .kill_count(a_kill)
  );

  pipe_skid_stage #(.DATA_W(64), .PC_W(32), .RESET_PC(32'hbfc00000), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_data(b_out_data),
    .occupancy(b_occ), .kill_count(b_kill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cyc(input logic rst, input logic fl, input logic v, input logic ordy,
                     input logic [31:0] pc, input bit check_en);
    logic [63:0] d;
    logic        ra, rb, acca, accb, popa, popb;
    @(negedge clk);
    d         = {$urandom, $urandom};
    reset     = rst;
    flush     = fl;
    in_valid  = v;
    out_ready = ordy;
    in_pc     = pc;
    in_data   = d;
    #1;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || ordy;
    if (check_en) begin
      chk("a_in_ready",  64'(a_in_ready),  64'(ra));
      chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      chk("a_out_pc",    64'(a_out_pc),    (qa.size() > 0) ? 64'(qa[0][95:64]) : 64'(RST_PC));
      chk("a_out_data",  a_out_data,       (qa.size() > 0) ? qa[0][63:0] : 64'd0);
      chk("a_occupancy", 64'(a_occ),       64'(qa.size()));
      chk("a_kill",      64'(a_kill),      64'(ka));
      chk("b_in_ready",  64'(b_in_ready),  64'(rb));
      chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      chk("b_out_pc",    64'(b_out_pc),    (qb.size() > 0) ? 64'(qb[0][95:64]) : 64'(RST_PC));
      chk("b_out_data",  b_out_data,       (qb.size() > 0) ? qb[0][63:0] : 64'd0);
      chk("b_occupancy", 64'(b_occ),       64'(qb.size()));
      chk("b_kill",      64'(b_kill),      64'(kb));
    end
    acca = v && ra;
    accb = v && rb;
    popa = ordy && (qa.size() > 0);
    popb = ordy && (qb.size() > 0);
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete(); ka = 0; kb = 0;
    end else if (fl) begin
      ka = sat255(ka + qa.size() - int'(popa) + int'(acca));
      kb = sat255(kb + qb.size() - int'(popb) + int'(accb));
      qa.delete(); qb.delete();
    end else begin
      if (popa) void'(qa.pop_front());
      if (acca) qa.push_back({pc, d});
      if (popb) void'(qb.pop_front());
      if (accb) qb.push_back({pc, d});
    end
  endtask

  initial begin
    // Reset: first edge brings the stage to a known state.
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 0, 32'h0, 1);

    // Fill without draining.
    cyc(0, 0, 1, 0, 32'h100, 1);
    cyc(0, 0, 1, 0, 32'h104, 1);
    #1;
    chk("fill_occ",   64'(a_occ),      64'd2);
    chk("fill_ready", 64'(a_in_ready), 64'd0);
    chk("fill_pc",    64'(a_out_pc),   64'h100);
    chk("fill_b_pc",  64'(b_out_pc),   64'h100);

    // Drain from TWO.
    cyc(0, 0, 0, 1, 32'h0, 1);
    #1;
    chk("drain_pc1", 64'(a_out_pc), 64'h104);
    cyc(0, 0, 0, 1, 32'h0, 1);
    #1;
    chk("drain_valid", 64'(a_out_valid), 64'd0);
    chk("drain_pc2",   64'(a_out_pc),    64'(RST_PC));

    // Full throughput: one entry per cycle, occupancy steady at one.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 1, 32'(i * 4), 1);
      #1;
      chk("thru_occ", 64'(a_occ),    64'd1);
      chk("thru_pc",  64'(a_out_pc), 64'(i * 4));
      chk("thru_b_pc", 64'(b_out_pc), 64'(i * 4));
    end
    cyc(0, 0, 0, 1, 32'h0, 1);

    // Flush in TWO with a simultaneous pop.
    cyc(0, 0, 1, 0, 32'h200, 1);
    cyc(0, 0, 1, 0, 32'h204, 1);
    cyc(0, 1, 0, 1, 32'h0, 1);
    #1;
    chk("flush_occ",  64'(a_occ),  64'd0);
    chk("flush_kill", 64'(a_kill), 64'd1);
    chk("flush_b_kill", 64'(b_kill), 64'd0);

    // Saturation: each cycle accepts one entry and flushes it.
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 1, 0, 32'(i), 1);
    end
    #1;
    chk("sat_kill",   64'(a_kill), 64'd255);
    chk("sat_b_kill", 64'(b_kill), 64'd255);
    cyc(1, 0, 0, 0, 32'h0, 1);
    #1;
    chk("sat_reset_kill", 64'(a_kill), 64'd0);

    // Reset while in TWO discards silently.
    cyc(0, 0, 1, 0, 32'h300, 1);
    cyc(0, 0, 1, 0, 32'h304, 1);
    cyc(1, 0, 0, 0, 32'h0, 1);
    #1;
    chk("rst_two_occ",  64'(a_occ),      64'd0);
    chk("rst_two_kill", 64'(a_kill),     64'd0);
    chk("rst_two_rdy",  64'(a_in_ready), 64'd1);

    // SKID=0 pass-through ready: held head blocks, out_ready frees same cycle.
    cyc(0, 0, 1, 0, 32'h400, 1);
    cyc(0, 0, 1, 0, 32'h404, 1);
    cyc(0, 0, 1, 1, 32'h408, 1);
    #1;
    chk("noskid_pc", 64'(b_out_pc), 64'h408);
    cyc(0, 0, 0, 1, 32'h0, 1);
    cyc(0, 0, 0, 1, 32'h0, 1);
    cyc(0, 0, 0, 1, 32'h0, 1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 150) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
          ($urandom % 3) != 0, $urandom, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
